// File: rtl/wb_ef_sram_ctrl.sv
// wb_ef_sram_ctrl: Wishbone classic (B4) 32-bit slave driving a banked
// EF_SRAM 1024x32 macro array. Writes ack two cycles after the request,
// reads three. All array-side strobes are registered; test/scan pins are
// tied low.
// Optional build macro EF_SRAM_CTRL_INIT_EN: after reset, a sequencer
// zero-fills every word before bus requests are served.
module wb_ef_sram_ctrl #(
  parameter int          RAM_BLOCKS = 2,
  parameter int          AW         = $clog2(RAM_BLOCKS) + 10,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  output logic          sram_en,
  output logic          sram_r_wb,
  output logic [31:0]   sram_ben,
  output logic [AW-1:0] sram_ad,
  output logic [31:0]   sram_di,
  input  logic [31:0]   sram_do,
  output logic          sram_tm,
  output logic          sram_sm,
  output logic          sram_wlbi,
  output logic          sram_wloff,
  output logic          sram_scanin_cc,
  output logic          sram_scanin_dl,
  output logic          sram_scanin_dr,
  output logic          init_busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCESS = 3'd1;
  localparam logic [2:0] S_RDCAP  = 3'd2;
  localparam logic [2:0] S_ACK    = 3'd3;
`ifdef EF_SRAM_CTRL_INIT_EN
  localparam logic [2:0] S_INIT   = 3'd4;
  localparam logic [2:0] S_RESET  = S_INIT;
`else
  localparam logic [2:0] S_RESET  = S_IDLE;
`endif

  logic [2:0]    r_state;
  logic          r_ack;
  logic [31:0]   r_dat_o;
  logic          r_en;
  logic          r_r_wb;
  logic [31:0]   r_ben;
  logic [AW-1:0] r_ad;
  logic [31:0]   r_di;
`ifdef EF_SRAM_CTRL_INIT_EN
  logic [AW-1:0] r_init_cnt;
`endif

  logic          w_hit;
  logic [31:0]   w_ben;
  logic          w_unused;

  // Window decode: upper address bits must match the aligned base.
  assign w_hit = wbs_cyc_i & wbs_stb_i &
                 (wbs_adr_i[31:AW+2] == BASE_ADDR[31:AW+2]);

  // Byte-lane offset is not meaningful for a word-wide array.
  assign w_unused = &{1'b0, wbs_adr_i[1:0]};

  // Expand byte selects into per-bit write enables; reads enable nothing.
  always_comb begin
    w_ben = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      w_ben[8*k +: 8] = {8{wbs_sel_i[k] & wbs_we_i}};
    end
  end

  // Main FSM plus registered array strobes and bus responses.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state <= S_RESET;
      r_ack   <= 1'b0;
      r_dat_o <= '0;
      r_en    <= 1'b0;
      r_r_wb  <= 1'b1;
      r_ben   <= '0;
      r_ad    <= '0;
      r_di    <= '0;
`ifdef EF_SRAM_CTRL_INIT_EN
      r_init_cnt <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_en    <= 1'b1;
            r_r_wb  <= ~wbs_we_i;
            r_ben   <= w_ben;
            r_ad    <= wbs_adr_i[AW+1:2];
            r_di    <= wbs_dat_i;
            r_state <= S_ACCESS;
          end else begin
            // Also retires the final clear-sequencer write.
            r_en  <= 1'b0;
            r_ben <= '0;
          end
        end
        S_ACCESS: begin
          r_en  <= 1'b0;
          r_ben <= '0;
          if (r_r_wb) begin
            r_state <= S_RDCAP;
          end else begin
            r_ack   <= 1'b1;
            r_state <= S_ACK;
          end
        end
        S_RDCAP: begin
          r_dat_o <= sram_do;
          r_ack   <= 1'b1;
          r_state <= S_ACK;
        end
        S_ACK: begin
          r_ack   <= 1'b0;
          r_state <= S_IDLE;
        end
`ifdef EF_SRAM_CTRL_INIT_EN
        S_INIT: begin
          r_en       <= 1'b1;
          r_r_wb     <= 1'b0;
          r_ben      <= '1;
          r_di       <= '0;
          r_ad       <= r_init_cnt;
          r_init_cnt <= r_init_cnt + 1'b1;
          if (r_init_cnt == '1) begin
            r_state <= S_IDLE;
          end
        end
`endif
        default: begin
          r_en    <= 1'b0;
          r_ben   <= '0;
          r_ack   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat_o;
  assign sram_en   = r_en;
  assign sram_r_wb = r_r_wb;
  assign sram_ben  = r_ben;
  assign sram_ad   = r_ad;
  assign sram_di   = r_di;

  assign sram_tm        = 1'b0;
  assign sram_sm        = 1'b0;
  assign sram_wlbi      = 1'b0;
  assign sram_wloff     = 1'b0;
  assign sram_scanin_cc = 1'b0;
  assign sram_scanin_dl = 1'b0;
  assign sram_scanin_dr = 1'b0;

`ifdef EF_SRAM_CTRL_INIT_EN
  assign init_busy = (r_state == S_INIT);
`else
  assign init_busy = 1'b0;
`endif

endmodule
